// File: rtl/lcd_fmt_pkg.sv
// Shared types and constants for the LCD value formatter: FSM states,
// ASCII codes and the per-bit double-dabble step.
package lcd_fmt_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CONV_A,
    CONV_B,
    FORMAT,
    SEND,
    WAIT_DONE,
    HOLDOFF
  } fmt_state_e;

  localparam logic [7:0] ASCII_SPACE   = 8'h20;
  localparam logic [7:0] ASCII_ZERO    = 8'h30;
  localparam logic [7:0] ASCII_A_UPPER = 8'h41;
  localparam logic [7:0] ASCII_X_LOWER = 8'h78;

  localparam int DEFAULT_LINE_LENGTH = 16;

  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    logic [7:0] c;
    if (nib < 4'd10) c = ASCII_ZERO + {4'h0, nib};
    else             c = ASCII_A_UPPER + {4'h0, nib} - 8'd10;
    return c;
  endfunction

  // One double-dabble iteration: add 3 to any digit >= 5, then shift in bit_in.
  function automatic logic [19:0] dd_step(input logic [19:0] bcd, input logic bit_in);
    logic [19:0] adj;
    adj = bcd;
    for (int k = 0; k < 5; k++) begin
      if (adj[4*k +: 4] >= 4'd5) adj[4*k +: 4] = adj[4*k +: 4] + 4'd3;
    end
    return {adj[18:0], bit_in};
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: 16-bit binary to 5-digit BCD. The first shift
// happens on the start edge, so done is high exactly 16 cycles after start.
module bin2bcd_seq
  import lcd_fmt_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic        start,
  input  logic [15:0] bin,
  output logic [19:0] bcd,
  output logic        done
);

  logic [15:0] shift_q, shift_d;
  logic [19:0] bcd_q, bcd_d;
  logic [4:0]  count_q, count_d;
  logic        active_q, active_d;

  always_comb begin
    shift_d  = shift_q;
    bcd_d    = bcd_q;
    count_d  = count_q;
    active_d = active_q;
    if (start) begin
      shift_d  = {bin[14:0], 1'b0};
      bcd_d    = dd_step(20'd0, bin[15]);
      count_d  = 5'd1;
      active_d = 1'b1;
    end else if (active_q && (count_q != 5'd16)) begin
      shift_d = {shift_q[14:0], 1'b0};
      bcd_d   = dd_step(bcd_q, shift_q[15]);
      count_d = count_q + 5'd1;
    end else if (active_q) begin
      active_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      shift_q  <= '0;
      bcd_q    <= '0;
      count_q  <= '0;
      active_q <= 1'b0;
    end else begin
      shift_q  <= shift_d;
      bcd_q    <= bcd_d;
      count_q  <= count_d;
      active_q <= active_d;
    end
  end

  // The result stays in bcd_q until the next start.
  assign bcd  = bcd_q;
  assign done = active_q && (count_q == 5'd16);

endmodule

// File: rtl/lcd_value_formatter.sv
// Formats two 16-bit values into two ASCII LCD lines and requests a refresh.
// Optional macro LCD_FMT_HEX_EN adds a hex_mode input for "0xNNNN" output.
module lcd_value_formatter
  import lcd_fmt_pkg::*;
#(
  parameter int          LINE_LENGTH        = DEFAULT_LINE_LENGTH,
  parameter int          MIN_REFRESH_CYCLES = 500000,
  parameter logic [15:0] LABEL_A            = "A:",
  parameter logic [15:0] LABEL_B            = "B:"
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [15:0]              value_a,
  input  logic [15:0]              value_b,
  input  logic                     update,
  input  logic                     sendingDone,
`ifdef LCD_FMT_HEX_EN
  input  logic                     hex_mode,
`endif
  output logic [8*LINE_LENGTH:1]   line1,
  output logic [8*LINE_LENGTH:1]   line2,
  output logic                     sendText,
  output logic                     busy
);

  localparam int          HOLD_CYCLES = (MIN_REFRESH_CYCLES < 1) ? 1 : MIN_REFRESH_CYCLES;
  localparam logic [31:0] HOLD_LAST   = 32'(HOLD_CYCLES - 1);
  localparam logic [8*LINE_LENGTH-1:0] BLANK_LINE = {LINE_LENGTH{ASCII_SPACE}};

  fmt_state_e state_q, state_d;
  logic        pending_q, pending_d;
  logic [31:0] hold_cnt_q, hold_cnt_d;
  logic        done_q, done_d;
  logic        done_prev_q, done_prev_d;
  logic [15:0] val_b_q, val_b_d;
  logic [19:0] bcd_a_q, bcd_a_d;
  logic [8*LINE_LENGTH:1] line1_q, line1_d;
  logic [8*LINE_LENGTH:1] line2_q, line2_d;
`ifdef LCD_FMT_HEX_EN
  logic [15:0] val_a_q, val_a_d;
  logic        hex_q, hex_d;
`endif

  logic        conv_start;
  logic [15:0] conv_bin;
  logic [19:0] conv_bcd;
  logic        conv_done;
  logic        launch;

  function automatic logic [8*LINE_LENGTH-1:0] fmt_dec(input logic [15:0] label,
                                                       input logic [19:0] bcd);
    logic [8*LINE_LENGTH-1:0] r;
    logic                     blank;
    logic [3:0]               dig;
    r = BLANK_LINE;
    r[8*LINE_LENGTH-1 -: 16] = label;
    blank = 1'b1;
    for (int k = 0; k < 5; k++) begin
      dig = bcd[19-4*k -: 4];
      if ((dig != 4'd0) || (k == 4)) blank = 1'b0;
      r[8*LINE_LENGTH-17-8*k -: 8] = blank ? ASCII_SPACE : (ASCII_ZERO + {4'h0, dig});
    end
    return r;
  endfunction

`ifdef LCD_FMT_HEX_EN
  function automatic logic [8*LINE_LENGTH-1:0] fmt_hex(input logic [15:0] label,
                                                       input logic [15:0] v);
    logic [8*LINE_LENGTH-1:0] r;
    r = BLANK_LINE;
    r[8*LINE_LENGTH-1 -: 16]  = label;
    r[8*LINE_LENGTH-17 -: 8]  = ASCII_ZERO;
    r[8*LINE_LENGTH-25 -: 8]  = ASCII_X_LOWER;
    for (int k = 0; k < 4; k++) begin
      r[8*LINE_LENGTH-33-8*k -: 8] = hex_char(v[15-4*k -: 4]);
    end
    return r;
  endfunction
`endif

  bin2bcd_seq u_bin2bcd (
    .CLK   (CLK),
    .RESET (RESET),
    .start (conv_start),
    .bin   (conv_bin),
    .bcd   (conv_bcd),
    .done  (conv_done)
  );

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    hold_cnt_d  = hold_cnt_q;
    done_d      = sendingDone;
    done_prev_d = done_q;
    val_b_d     = val_b_q;
    bcd_a_d     = bcd_a_q;
    line1_d     = line1_q;
    line2_d     = line2_q;
`ifdef LCD_FMT_HEX_EN
    val_a_d     = val_a_q;
    hex_d       = hex_q;
`endif
    conv_start  = 1'b0;
    conv_bin    = value_a;
    launch      = 1'b0;

    if ((state_q != IDLE) && update) pending_d = 1'b1;

    case (state_q)
      IDLE: launch = update;
      CONV_A: begin
        if (conv_done) begin
          bcd_a_d    = conv_bcd;
          conv_start = 1'b1;
          conv_bin   = val_b_q;
          state_d    = CONV_B;
        end
      end
      CONV_B: if (conv_done) state_d = FORMAT;
      // B's BCD is still held in the converter here; A's was captured earlier.
      FORMAT: begin
`ifdef LCD_FMT_HEX_EN
        if (hex_q) begin
          line1_d = fmt_hex(LABEL_A, val_a_q);
          line2_d = fmt_hex(LABEL_B, val_b_q);
        end else
`endif
        begin
          line1_d = fmt_dec(LABEL_A, bcd_a_q);
          line2_d = fmt_dec(LABEL_B, conv_bcd);
        end
        state_d = SEND;
      end
      SEND: state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (done_q && !done_prev_q) begin
          hold_cnt_d = '0;
          state_d    = HOLDOFF;
        end
      end
      HOLDOFF: begin
        if (hold_cnt_q == HOLD_LAST) begin
          if (pending_q || update) begin
            pending_d = 1'b0;
            launch    = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // In decimal mode A lives in the converter's shift register from this edge on.
    if (launch) begin
      val_b_d = value_b;
`ifdef LCD_FMT_HEX_EN
      val_a_d = value_a;
      hex_d   = hex_mode;
      if (hex_mode) begin
        state_d = FORMAT;
      end else
`endif
      begin
        conv_start = 1'b1;
        conv_bin   = value_a;
        state_d    = CONV_A;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      pending_q   <= 1'b0;
      hold_cnt_q  <= '0;
      done_q      <= 1'b0;
      done_prev_q <= 1'b0;
      val_b_q     <= '0;
      bcd_a_q     <= '0;
      line1_q     <= BLANK_LINE;
      line2_q     <= BLANK_LINE;
`ifdef LCD_FMT_HEX_EN
      val_a_q     <= '0;
      hex_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      hold_cnt_q  <= hold_cnt_d;
      done_q      <= done_d;
      done_prev_q <= done_prev_d;
      val_b_q     <= val_b_d;
      bcd_a_q     <= bcd_a_d;
      line1_q     <= line1_d;
      line2_q     <= line2_d;
`ifdef LCD_FMT_HEX_EN
      val_a_q     <= val_a_d;
      hex_q       <= hex_d;
`endif
    end
  end

  assign line1    = line1_q;
  assign line2    = line2_q;
  assign sendText = (state_q == SEND);
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_lcd_value_formatter.sv
// Self-checking bench for lcd_value_formatter with randomized values checked
// against a string-formatting reference model.
module tb_lcd_value_formatter;

  localparam int LL   = 16;
  localparam int HOLD = 100;
`ifdef LCD_FMT_HEX_EN
  localparam bit HEX_EN = 1'b1;
`else
  localparam bit HEX_EN = 1'b0;
`endif
  localparam logic [8*LL-1:0] SPACES = {LL{8'h20}};

  logic          CLK = 1'b0;
  logic          RESET;
  logic [15:0]   value_a, value_b;
  logic          update, sendingDone;
`ifdef LCD_FMT_HEX_EN
  logic          hexMode;
`endif
  logic [8*LL:1] line1, line2;
  logic          sendText, busy;

  int vectors     = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  lcd_value_formatter #(
    .LINE_LENGTH        (LL),
    .MIN_REFRESH_CYCLES (HOLD),
    .LABEL_A            ("A:"),
    .LABEL_B            ("B:")
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .value_a     (value_a),
    .value_b     (value_b),
    .update      (update),
    .sendingDone (sendingDone),
`ifdef LCD_FMT_HEX_EN
    .hex_mode    (hexMode),
`endif
    .line1       (line1),
    .line2       (line2),
    .sendText    (sendText),
    .busy        (busy)
  );

  task automatic checkOutput(input string tag, input logic [127:0] actual,
                             input logic [127:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Reference model: the line is just the printf-style rendering, space padded.
  function automatic logic [8*LL-1:0] expLine(input string label, input int v, input bit hex);
    string s;
    string h;
    logic [8*LL-1:0] r;
    if (hex) begin
      h = $sformatf("%04h", v & 16'hFFFF);
      s = {label, "0x", h.toupper()};
    end else begin
      s = $sformatf("%s%5d", label, v);
    end
    r = SPACES;
    for (int i = 0; i < LL; i++) begin
      if (i < s.len()) r[8*LL-1-8*i -: 8] = s[i];
    end
    return r;
  endfunction

  // Counts cycles after the current point until sendText is seen; -1 on timeout.
  task automatic waitSend(input int maxCycles, output int n);
    n = -1;
    for (int i = 1; i <= maxCycles; i++) begin
      @(negedge CLK);
      if (sendText) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic startTxn(input int a, input int b, input bit hex);
    @(posedge CLK); #1;
    value_a = a[15:0];
    value_b = b[15:0];
`ifdef LCD_FMT_HEX_EN
    hexMode = hex;
`endif
    update = 1'b1;
    @(posedge CLK); #1;
    update = 1'b0;
  endtask

  task automatic applyStimulus(input int a, input int b, input bit hex);
    bit useHex;
    int n;
    useHex = hex && HEX_EN;
    startTxn(a, b, hex);
    waitSend(60, n);
    checkOutput("latency", n, useHex ? 2 : 34);
    checkOutput("line1", line1, expLine("A:", a, useHex));
    checkOutput("line2", line2, expLine("B:", b, useHex));
    @(negedge CLK);
    checkOutput("pulseWidth", sendText, 1'b0);
    checkOutput("busyWaitDone", busy, 1'b1);
  endtask

  // Gives a fresh sendingDone edge and checks HOLDOFF length; leaves sendingDone high.
  task automatic finishRefresh();
    @(posedge CLK); #1 sendingDone = 1'b0;
    repeat (2) @(posedge CLK);
    #1 sendingDone = 1'b1;
    @(posedge CLK); #1;
    checkOutput("busyAfterDone", busy, 1'b1);
    repeat (HOLD) @(posedge CLK);
    #1 checkOutput("busyLastHold", busy, 1'b1);
    @(posedge CLK);
    #1 checkOutput("idleAfterHold", busy, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n, ra, rb, ra3, rb3, rb2;
    bit sawSend, hx;

    RESET = 1'b1; update = 1'b0; sendingDone = 1'b0;
    value_a = '0; value_b = '0;
`ifdef LCD_FMT_HEX_EN
    hexMode = 1'b0;
`endif
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("rstBusy", busy, 1'b0);
    checkOutput("rstSend", sendText, 1'b0);
    checkOutput("rstLine1", line1, SPACES);
    checkOutput("rstLine2", line2, SPACES);
    RESET = 1'b0;

    $display("[TB] basic decimal refreshes");
    applyStimulus(12345, 0, 1'b0);
    finishRefresh();
    applyStimulus(65535, 7, 1'b0);
    finishRefresh();

    $display("[TB] update while busy, stale sendingDone level");
    ra = int'($urandom_range(0, 65535));
    rb = int'($urandom_range(0, 65535));
    applyStimulus(ra, rb, 1'b0);
    value_a = 16'd42;
    value_b = 16'($urandom_range(0, 65535));
    update  = 1'b1;
    sawSend = 1'b0;
    for (int i = 0; i < 150; i++) begin
      @(negedge CLK);
      if (sendText) sawSend = 1'b1;
    end
    checkOutput("noAdvanceSend", sawSend, 1'b0);
    checkOutput("noAdvanceBusy", busy, 1'b1);

    @(posedge CLK); #1 sendingDone = 1'b0;
    repeat (2) @(posedge CLK);
    #1 sendingDone = 1'b1;
    @(posedge CLK); #1;
    sawSend = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      if (sendText) sawSend = 1'b1;
    end
    rb2 = int'($urandom_range(0, 65535));
    value_b = rb2[15:0];
    waitSend(120, n);
    update = 1'b0;
    checkOutput("noEarlySend", sawSend, 1'b0);
    checkOutput("pendingLatency", (n < 0) ? -1 : 50 + n, 135);
    checkOutput("pendingLine1", line1, expLine("A:", 42, 1'b0));
    checkOutput("pendingLine2", line2, expLine("B:", rb2, 1'b0));

    ra3 = int'($urandom_range(0, 65535));
    rb3 = int'($urandom_range(0, 65535));
    value_a = ra3[15:0];
    value_b = rb3[15:0];
    @(posedge CLK); #1 sendingDone = 1'b0;
    repeat (2) @(posedge CLK);
    #1 sendingDone = 1'b1;
    @(posedge CLK); #1;
    waitSend(160, n);
    checkOutput("rePendLatency", n, 135);
    checkOutput("rePendLine1", line1, expLine("A:", ra3, 1'b0));
    checkOutput("rePendLine2", line2, expLine("B:", rb3, 1'b0));
    @(negedge CLK);
    finishRefresh();

    $display("[TB] reset during CONV_B");
    startTxn(int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)), 1'b0);
    repeat (20) @(posedge CLK);
    #1 RESET = 1'b1;
    @(posedge CLK); #1;
    checkOutput("midRstBusy", busy, 1'b0);
    checkOutput("midRstSend", sendText, 1'b0);
    checkOutput("midRstLine1", line1, SPACES);
    checkOutput("midRstLine2", line2, SPACES);
    RESET = 1'b0;
    applyStimulus(int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)), 1'b0);
    finishRefresh();

    $display("[TB] randomized refreshes");
    for (int k = 0; k < 6; k++) begin
      ra = (k == 0) ? 0 : int'($urandom_range(0, 65535));
      rb = (k == 1) ? 65535 : int'($urandom_range(0, 999));
      hx = 1'($urandom_range(0, 1));
      applyStimulus(ra, rb, hx);
      finishRefresh();
    end

    $display("[TB] hex request");
    applyStimulus(16'hBEEF, 16'h0001, 1'b1);
    finishRefresh();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
